xbus_tag_receiver: RTL and testbench

//  PE-column end of the X-bus: snoops the ifmap/fltr/psum G2B words and X_TAG broadcast by the
//  bus driver, captures the words whose tag equals this column's ID during a flush window,

---
 rtl/xbus_tag_receiver_pkg.sv | 33 +++
 rtl/xbus_tag_receiver_rx_fifo.sv | 54 +++++
 rtl/xbus_tag_receiver.sv | 132 +++++++++++++
 tb/tb_xbus_tag_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_tag_receiver_pkg.sv
// Shared types and constants for the X-bus tag receiver at the PE-column end of the bus.
package xbus_tag_receiver_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int NUM_COL_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    // Tag/ID width: enough bits to encode every column plus one extra,
    // so the wrap value (kernel_size) can appear on the bus.
    function automatic int tag_width(input int num_col);
        return $clog2(num_col) + 1;
    endfunction

    // Receive FSM encodings, kept as plain constants for older code that
    // compares the raw state value.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE,
        DRAIN  = ST_DRAIN
    } rx_state_t;

    // One captured bus beat at the default data width.
    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]   ifmap;
        logic [DATA_WIDTH_DEF-1:0]   fltr;
        logic [2*DATA_WIDTH_DEF-1:0] psum;
    } xbus_word_t;

endpackage

// File: rtl/xbus_tag_receiver_rx_fifo.sv
// Small synchronous capture FIFO. The head entry is visible on o_head as
// soon as it is written (no extra read stage), and reads as zero while empty.
module xbus_tag_receiver_rx_fifo
    import xbus_tag_receiver_pkg::*;
#(
    parameter type word_t = xbus_word_t,
    parameter int  DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  i_push,
    input  word_t i_data,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_empty,
    output word_t o_head
);

    localparam int AW = $clog2(DEPTH);

    word_t          r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointers, wrapping naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/xbus_tag_receiver.sv
// PE-column receiver on the X-bus: during a flush window captures the bus
// beats whose tag equals this column's ID, queues them, hands them to the PE
// over valid/ready and pulses window_done once the window closed and drained.
module xbus_tag_receiver
    import xbus_tag_receiver_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int NUM_COL    = NUM_COL_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int TAG_W      = tag_width(NUM_COL)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [TAG_W-1:0]        i_x_id,
    input  logic                    i_flush,
    input  logic [7:0]              i_kernel_size,
    input  logic [TAG_W-1:0]        i_x_tag,
    input  logic [DATA_WIDTH-1:0]   i_ifmap_g2b,
    input  logic [DATA_WIDTH-1:0]   i_fltr_g2b,
    input  logic [2*DATA_WIDTH-1:0] i_psum_g2b,
    output logic                    o_pe_valid,
    input  logic                    i_pe_ready,
    output logic [DATA_WIDTH-1:0]   o_pe_ifmap,
    output logic [DATA_WIDTH-1:0]   o_pe_fltr,
    output logic [2*DATA_WIDTH-1:0] o_pe_psum,
    output logic [7:0]              o_rx_count,
    output logic                    o_overflow,
    output logic                    o_window_done
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   ifmap;
        logic [DATA_WIDTH-1:0]   fltr;
        logic [2*DATA_WIDTH-1:0] psum;
    } word_t;

    rx_state_t  r_state;
    logic [7:0] r_rx_count;
    logic       r_overflow;
    logic       r_window_done;

    logic [7:0] w_tag_ext;
    logic       w_tag_in_range;
    logic       w_exit;
    logic       w_push_req;
    logic       w_push_ok;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    word_t      w_bus_word;
    word_t      w_head;

    assign w_tag_ext      = 8'(i_x_tag);
    assign w_tag_in_range = (w_tag_ext < i_kernel_size);
    // Window ends when flush drops or the tag sequence wraps; an empty
    // kernel has no valid tags at all, so it closes on the first cycle.
    assign w_exit         = !i_flush || (w_tag_ext == i_kernel_size) ||
                            (i_kernel_size == 8'd0);
    // A match already implies !w_exit, so the exit-cycle beat is never taken.
    assign w_push_req     = (r_state == ACTIVE) && i_flush &&
                            (i_x_tag == i_x_id) && w_tag_in_range;
    assign w_pop          = o_pe_valid && i_pe_ready;
    assign w_push_ok      = w_push_req && (!w_full || w_pop);

    assign w_bus_word.ifmap = i_ifmap_g2b;
    assign w_bus_word.fltr  = i_fltr_g2b;
    assign w_bus_word.psum  = i_psum_g2b;

    xbus_tag_receiver_rx_fifo #(
        .word_t (word_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push_req),
        .i_data  (w_bus_word),
        .i_pop   (i_pe_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign o_pe_valid    = !w_empty;
    assign o_pe_ifmap    = w_head.ifmap;
    assign o_pe_fltr     = w_head.fltr;
    assign o_pe_psum     = w_head.psum;
    assign o_rx_count    = r_rx_count;
    assign o_overflow    = r_overflow;
    assign o_window_done = r_window_done;

    // Window FSM: open on flush, close on flush drop/tag wrap, wait for drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_flush) r_state <= ACTIVE;
                ACTIVE:  if (w_exit)  r_state <= DRAIN;
                DRAIN:   if (w_empty) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-window capture count (saturating) and sticky drop flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_count <= 8'd0;
            r_overflow <= 1'b0;
        end else if ((r_state == IDLE) && i_flush) begin
            r_rx_count <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok && (r_rx_count != 8'hFF)) begin
                r_rx_count <= r_rx_count + 8'd1;
            end
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // One-cycle done pulse when the drain phase finds the FIFO empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_window_done <= 1'b0;
        end else begin
            r_window_done <= (r_state == DRAIN) && w_empty;
        end
    end

endmodule

// File: tb/tb_xbus_tag_receiver.sv
// Bench for the X-bus tag receiver: directed windows plus random windows,
// checked every cycle against a queue-based model of the capture rules.
module tb_xbus_tag_receiver;

    localparam int DW    = 16;
    localparam int TW    = 3;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic [TW-1:0]   x_id;
    logic            flush;
    logic [7:0]      kernel_size;
    logic [TW-1:0]   x_tag;
    logic [DW-1:0]   ifmap_g2b;
    logic [DW-1:0]   fltr_g2b;
    logic [2*DW-1:0] psum_g2b;
    logic            pe_valid;
    logic            pe_ready;
    logic [DW-1:0]   pe_ifmap;
    logic [DW-1:0]   pe_fltr;
    logic [2*DW-1:0] pe_psum;
    logic [7:0]      rx_count;
    logic            overflow;
    logic            window_done;

    xbus_tag_receiver #(
        .DATA_WIDTH (DW),
        .NUM_COL    (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_x_id        (x_id),
        .i_flush       (flush),
        .i_kernel_size (kernel_size),
        .i_x_tag       (x_tag),
        .i_ifmap_g2b   (ifmap_g2b),
        .i_fltr_g2b    (fltr_g2b),
        .i_psum_g2b    (psum_g2b),
        .o_pe_valid    (pe_valid),
        .i_pe_ready    (pe_ready),
        .o_pe_ifmap    (pe_ifmap),
        .o_pe_fltr     (pe_fltr),
        .o_pe_psum     (pe_psum),
        .o_rx_count    (rx_count),
        .o_overflow    (overflow),
        .o_window_done (window_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_no  = 0;

    // Reference model: queued words, window open / draining flags, counters.
    logic [63:0] m_q[$];
    bit          m_open;
    bit          m_drain;
    int          m_count;
    bit          m_ovf;
    bit          m_done;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_open  = 1'b0;
        m_drain = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs held across that edge.
    task automatic model_edge();
        int          sz0;
        bit          pop;
        bit          push;
        bit          done_nxt;
        logic [63:0] word;
        sz0      = m_q.size();
        pop      = (sz0 > 0) && pe_ready;
        push     = 1'b0;
        done_nxt = 1'b0;
        word     = {ifmap_g2b, fltr_g2b, psum_g2b};
        if (m_open) begin
            if (!flush || int'(x_tag) == int'(kernel_size) || kernel_size == 8'd0) begin
                m_open  = 1'b0;
                m_drain = 1'b1;
            end else if (x_tag == x_id && int'(x_tag) < int'(kernel_size)) begin
                if (sz0 < DEPTH || pop) begin
                    push = 1'b1;
                    if (m_count < 255) m_count++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end else if (m_drain) begin
            if (sz0 == 0) begin
                m_drain  = 1'b0;
                done_nxt = 1'b1;
            end
        end else if (flush) begin
            m_open  = 1'b1;
            m_count = 0;
            m_ovf   = 1'b0;
        end
        if (pop) begin
            $display("xfer cyc=%0d word=%016h", cyc_no, m_q[0]);
            void'(m_q.pop_front());
        end
        if (push) m_q.push_back(word);
        if (done_nxt) $display("window done cyc=%0d rx_count=%0d", cyc_no, m_count);
        m_done = done_nxt;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_word;
        exp_word = (m_q.size() > 0) ? m_q[0] : 64'd0;
        check_val("pe_valid", 64'(pe_valid), 64'(m_q.size() > 0));
        check_val("pe_data", {pe_ifmap, pe_fltr, pe_psum}, exp_word);
        check_val("rx_count", 64'(rx_count), 64'(m_count));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("window_done", 64'(window_done), 64'(m_done));
    endtask

    // Drive one bus cycle, step the clock and compare just after the edge.
    task automatic cyc(input bit f, input int tag, input bit rdy);
        flush     = f;
        x_tag     = TW'(tag);
        pe_ready  = rdy;
        ifmap_g2b = DW'($urandom);
        fltr_g2b  = DW'($urandom);
        psum_g2b  = $urandom;
        @(posedge clk);
        model_edge();
        #1;
        cyc_no++;
        check_outputs();
    endtask

    initial begin
        rstn        = 1'b0;
        flush       = 1'b0;
        x_tag       = '0;
        x_id        = '0;
        kernel_size = 8'd4;
        pe_ready    = 1'b0;
        ifmap_g2b   = '0;
        fltr_g2b    = '0;
        psum_g2b    = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        #2 rstn = 1'b1;

        // Single match at tag 2 in a 4-tag window.
        x_id = 3'd2; kernel_size = 8'd4;
        for (int k = 0; k < 6; k++) cyc(1'b1, k, 1'b1);
        repeat (4) cyc(1'b0, 0, 1'b1);

        // Column ID outside the kernel never matches.
        x_id = 3'd3; kernel_size = 8'd2;
        for (int k = 0; k < 4; k++) cyc(1'b1, k, 1'b1);
        repeat (4) cyc(1'b0, 0, 1'b1);

        // Stalled PE: five matches into a four-entry FIFO, one dropped.
        x_id = 3'd1; kernel_size = 8'd4;
        cyc(1'b1, 0, 1'b0);
        repeat (5) cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 2, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b0);
        repeat (8) cyc(1'b0, 0, 1'b1);

        // Full FIFO with a simultaneous pop: push accepted, no drop.
        x_id = 3'd0; kernel_size = 8'd3;
        cyc(1'b1, 0, 1'b0);
        repeat (4) cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 0, 1'b1);
        cyc(1'b1, 1, 1'b0);
        cyc(1'b0, 0, 1'b0);
        repeat (8) cyc(1'b0, 0, 1'b1);

        // Asynchronous reset mid-window with two words queued.
        x_id = 3'd2; kernel_size = 8'd4;
        cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 2, 1'b0);
        cyc(1'b1, 2, 1'b0);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1 rstn = 1'b1;
        repeat (4) cyc(1'b0, 0, 1'b1);

        // Empty kernel: window opens and closes with a done pulse.
        x_id = 3'd0; kernel_size = 8'd0;
        repeat (3) cyc(1'b1, 0, 1'b1);
        repeat (3) cyc(1'b0, 0, 1'b1);

        // Random windows: random ID/kernel, mostly sequential tags, random PE stalls.
        for (int w = 0; w < 25; w++) begin
            int flen;
            x_id        = TW'($urandom_range(0, 4));
            kernel_size = 8'($urandom_range(0, 5));
            flen        = int'($urandom_range(1, 8));
            for (int k = 0; k < flen; k++) begin
                int t;
                t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : (k % 8);
                cyc(1'b1, t, $urandom_range(0, 2) != 0);
            end
            repeat (12) cyc(1'b0, 0, $urandom_range(0, 3) != 0);
        end
        repeat (6) cyc(1'b0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
